// File: rtl/gpio_pkg.sv
// Shared definitions for the GPIO AHB-Lite slaves: register word offsets,
// AHB transfer encodings and the byte-lane mask helper.
package gpio_pkg;

  // Register word offsets, i.e. the value of HADDR[4:2].
  localparam logic [2:0] GPIO_OFF_DATA = 3'd0;  // byte offset 0x00
  localparam logic [2:0] GPIO_OFF_OE   = 3'd1;  // byte offset 0x04
  localparam logic [2:0] GPIO_OFF_SET  = 3'd2;  // byte offset 0x08
  localparam logic [2:0] GPIO_OFF_CLR  = 3'd3;  // byte offset 0x0C
  localparam logic [2:0] GPIO_OFF_TGL  = 3'd4;  // byte offset 0x10
  localparam logic [2:0] GPIO_OFF_IN   = 3'd5;  // byte offset 0x14

  // HTRANS encodings.
  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  // HSIZE encodings (anything wider than a word is handled as a word).
  localparam logic [2:0] HSIZE_BYTE = 3'b000;
  localparam logic [2:0] HSIZE_HALF = 3'b001;
  localparam logic [2:0] HSIZE_WORD = 3'b010;

  // Byte lanes touched by a transfer of size hsize at byte address addr.
  function automatic logic [3:0] ahb_lane_mask(input logic [2:0] hsize,
                                               input logic [1:0] addr);
    logic [3:0] m;
    case (hsize)
      HSIZE_BYTE: m = 4'b0001 << addr;
      HSIZE_HALF: m = addr[1] ? 4'b1100 : 4'b0011;
      default:    m = 4'b1111;
    endcase
    return m;
  endfunction

  // Expand a 4-bit lane mask into a 32-bit bit mask.
  function automatic logic [31:0] ahb_lane_bits(input logic [3:0] lanes);
    return {{8{lanes[3]}}, {8{lanes[2]}}, {8{lanes[1]}}, {8{lanes[0]}}};
  endfunction

endpackage

// File: rtl/gpio_sync2.sv
// Two-flop synchroniser bringing asynchronous pin levels into the bus clock.
module gpio_sync2 #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta;

  // First stage may go metastable; second stage gives it a cycle to settle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta <= '0;
      q    <= '0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/ahblite_gpio_write.sv
// AHB-Lite slave owning the GPIO output data and output-enable registers,
// with atomic SET/CLR/TGL aliases and a synchronised pin readback.
// Zero wait states, always OKAY.
module ahblite_gpio_write
  import gpio_pkg::*;
#(
  parameter int unsigned GPIO_WIDTH = 8,
  parameter logic [31:0] DATA_RESET = 32'h0,
  parameter logic [31:0] OE_RESET   = 32'h0
) (
  input  logic                  HCLK,
  input  logic                  HRESET,
  input  logic                  HSEL,
  input  logic [31:0]           HADDR,
  input  logic [1:0]            HTRANS,
  input  logic [2:0]            HSIZE,
  input  logic [3:0]            HPROT,
  input  logic                  HWRITE,
  input  logic [31:0]           HWDATA,
  input  logic                  HREADY,
  output logic                  HREADYOUT,
  output logic [31:0]           HRDATA,
  output logic                  HRESP,
  output logic [GPIO_WIDTH-1:0] IO_WRITE,
  output logic [GPIO_WIDTH-1:0] IO_OE,
  input  logic [GPIO_WIDTH-1:0] IO_IN
);

  // Handshake: an address phase is taken on a rising edge when
  // HSEL & HREADY & HTRANS[1]; its data phase occupies the following cycle
  // and always completes at the next edge because HREADYOUT is tied high.
  // Any other cycle leaves no transfer pending.
  logic                  accept;
  logic                  wr_pend;
  logic                  rd_pend;
  logic [2:0]            addr_q;
  logic [3:0]            lane_q;
  logic [GPIO_WIDTH-1:0] data_q;
  logic [GPIO_WIDTH-1:0] oe_q;
  logic [GPIO_WIDTH-1:0] in_sync;
  logic [31:0]           mask_full;
  logic [31:0]           wbits_full;
  logic [GPIO_WIDTH-1:0] mbits;
  logic [GPIO_WIDTH-1:0] wbits;
  logic [31:0]           rdata;
  logic                  unused_ok;

  assign accept = HSEL & HREADY & HTRANS[1];

  // Write data restricted to the lanes captured in the address phase; bits
  // outside those lanes read as zero so SET/CLR/TGL leave them alone.
  assign mask_full  = ahb_lane_bits(lane_q);
  assign wbits_full = HWDATA & mask_full;
  assign mbits      = mask_full[GPIO_WIDTH-1:0];
  assign wbits      = wbits_full[GPIO_WIDTH-1:0];

  // Address-phase capture; a new capture and the previous data phase share
  // the same edge, so pending state is simply overwritten each cycle.
  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      wr_pend <= 1'b0;
      rd_pend <= 1'b0;
      addr_q  <= '0;
      lane_q  <= '0;
    end else begin
      wr_pend <= accept & HWRITE;
      rd_pend <= accept & ~HWRITE;
      if (accept) begin
        addr_q <= HADDR[4:2];
        lane_q <= ahb_lane_mask(HSIZE, HADDR[1:0]);
      end
    end
  end

  // Data-phase register update, applied at the edge ending the write.
  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      data_q <= DATA_RESET[GPIO_WIDTH-1:0];
      oe_q   <= OE_RESET[GPIO_WIDTH-1:0];
    end else if (wr_pend) begin
      case (addr_q)
        GPIO_OFF_DATA: data_q <= (data_q & ~mbits) | wbits;
        GPIO_OFF_OE:   oe_q   <= (oe_q & ~mbits) | wbits;
        GPIO_OFF_SET:  data_q <= data_q | wbits;
        GPIO_OFF_CLR:  data_q <= data_q & ~wbits;
        GPIO_OFF_TGL:  data_q <= data_q ^ wbits;
        default: ;
      endcase
    end
  end

  gpio_sync2 #(.WIDTH(GPIO_WIDTH)) u_sync (
    .clk (HCLK),
    .rst (HRESET),
    .d   (IO_IN),
    .q   (in_sync)
  );

  // Read mux; driven only while a read data phase is in progress.
  always_comb begin
    rdata = '0;
    if (rd_pend) begin
      case (addr_q)
        GPIO_OFF_DATA, GPIO_OFF_SET,
        GPIO_OFF_CLR,  GPIO_OFF_TGL: rdata[GPIO_WIDTH-1:0] = data_q;
        GPIO_OFF_OE:                 rdata[GPIO_WIDTH-1:0] = oe_q;
        GPIO_OFF_IN:                 rdata[GPIO_WIDTH-1:0] = in_sync;
        default: ;
      endcase
    end
  end

  assign HRDATA    = rdata;
  assign HREADYOUT = 1'b1;
  assign HRESP     = 1'b0;
  assign IO_WRITE  = data_q;
  assign IO_OE     = oe_q;

  // Bus fields that carry no meaning for this slave.
  assign unused_ok = ^{HPROT, HADDR[31:5], HTRANS[0], wbits_full, mask_full};

endmodule

// File: tb/tb_ahblite_gpio_write.sv
// Self-checking bench for ahblite_gpio_write: directed register-map cases,
// randomized pipelined traffic against a behavioural register model, and
// an asynchronous reset in the middle of a write.
module tb_ahblite_gpio_write;
  import gpio_pkg::*;

  localparam int W = 8;

  // ---------------- clock / reset ----------------
  logic         HCLK = 1'b0;
  logic         HRESET;
  logic         HSEL;
  logic [31:0]  HADDR;
  logic [1:0]   HTRANS;
  logic [2:0]   HSIZE;
  logic [3:0]   HPROT;
  logic         HWRITE;
  logic [31:0]  HWDATA;
  logic         HREADY;
  logic         HREADYOUT;
  logic [31:0]  HRDATA;
  logic         HRESP;
  logic [W-1:0] IO_WRITE;
  logic [W-1:0] IO_OE;
  logic [W-1:0] IO_IN;

  always #5 HCLK = ~HCLK;

  ahblite_gpio_write #(.GPIO_WIDTH(W)) dut (
    .HCLK      (HCLK),
    .HRESET    (HRESET),
    .HSEL      (HSEL),
    .HADDR     (HADDR),
    .HTRANS    (HTRANS),
    .HSIZE     (HSIZE),
    .HPROT     (HPROT),
    .HWRITE    (HWRITE),
    .HWDATA    (HWDATA),
    .HREADY    (HREADY),
    .HREADYOUT (HREADYOUT),
    .HRDATA    (HRDATA),
    .HRESP     (HRESP),
    .IO_WRITE  (IO_WRITE),
    .IO_OE     (IO_OE),
    .IO_IN     (IO_IN)
  );

  // ---------------- scoreboard state ----------------
  int           n_checks = 0;
  int           n_errors = 0;
  logic [31:0]  exp_q[$];
  logic [W-1:0] m_data;
  logic [W-1:0] m_oe;
  logic [W-1:0] pin_hist[$];
  logic         prev_valid;
  logic         prev_wr;
  logic [31:0]  prev_addr;
  logic [2:0]   prev_size;
  logic [31:0]  prev_wdata;
  logic [31:0]  last_rd;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  // Bytes covered: 1/2/4 bytes by size, aligned down to the transfer size.
  function automatic logic [31:0] model_bytemask(input logic [2:0] size, input logic [31:0] addr);
    int          nbytes;
    int          first;
    logic [31:0] m;
    nbytes = (size == 3'd0) ? 1 : (size == 3'd1) ? 2 : 4;
    first  = (int'(addr[1:0]) / nbytes) * nbytes;
    m = 32'h0;
    for (int b = 0; b < 4; b++)
      if (b >= first && b < first + nbytes) m[8*b +: 8] = 8'hFF;
    return m;
  endfunction

  task automatic model_commit(input logic [31:0] addr, input logic [2:0] size, input logic [31:0] wdata);
    logic [31:0] bm;
    logic [31:0] wd;
    bm = model_bytemask(size, addr);
    wd = wdata & bm;
    case (int'(addr[4:2]))
      0: m_data = (m_data & ~bm[W-1:0]) | wd[W-1:0];
      1: m_oe   = (m_oe & ~bm[W-1:0]) | wd[W-1:0];
      2: m_data = m_data | wd[W-1:0];
      3: m_data = m_data & ~wd[W-1:0];
      4: m_data = m_data ^ wd[W-1:0];
      default: ;
    endcase
  endtask

  // Pin value that has had two clock edges to cross into the bus domain.
  function automatic logic [W-1:0] pin_visible();
    if (pin_hist.size() >= 2) return pin_hist[pin_hist.size()-2];
    return '0;
  endfunction

  function automatic logic [31:0] model_read(input logic [31:0] addr);
    case (int'(addr[4:2]))
      0, 2, 3, 4: return 32'(m_data);
      1:          return 32'(m_oe);
      5:          return 32'(pin_visible());
      default:    return 32'h0;
    endcase
  endfunction

  // ---------------- driver ----------------
  // One bus cycle, entered #1 after a rising edge: drives the address phase
  // of a new transfer and the write data of the previous one, checks the
  // read data of the previous one, then advances one edge.
  task automatic bus_cycle(input logic v, input logic wr, input logic [31:0] addr,
                           input logic [2:0] size, input logic [31:0] wdata,
                           input logic sel = 1'b1, input logic rdy = 1'b1);
    HSEL   = sel;
    HREADY = rdy;
    if (v) HTRANS = ($urandom_range(0, 1) == 1) ? HTRANS_NONSEQ : HTRANS_SEQ;
    else   HTRANS = ($urandom_range(0, 1) == 1) ? HTRANS_IDLE : HTRANS_BUSY;
    HADDR  = addr;
    HWRITE = wr;
    HSIZE  = size;
    HPROT  = 4'($urandom_range(0, 15));
    HWDATA = prev_wdata;
    #1;
    if (prev_valid && !prev_wr) begin
      exp_q.push_back(model_read(prev_addr));
      last_rd = HRDATA;
      check("rd_data", HRDATA, exp_q.pop_front());
    end else begin
      check("rd_idle_zero", HRDATA, 32'h0);
    end
    @(posedge HCLK);
    if (prev_valid && prev_wr) model_commit(prev_addr, prev_size, prev_wdata);
    pin_hist.push_back(IO_IN);
    if (pin_hist.size() > 4) void'(pin_hist.pop_front());
    #1;
    check("io_write", 32'(IO_WRITE), 32'(m_data));
    check("io_oe", 32'(IO_OE), 32'(m_oe));
    prev_valid = v && sel && rdy;
    prev_wr    = wr;
    prev_addr  = addr;
    prev_size  = size;
    prev_wdata = wdata;
  endtask

  task automatic idle();
    bus_cycle(1'b0, 1'b0, 32'h0, HSIZE_WORD, 32'h0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    HRESET = 1'b1;
    HSEL = 1'b0; HADDR = '0; HTRANS = HTRANS_IDLE; HSIZE = HSIZE_WORD;
    HPROT = '0; HWRITE = 1'b0; HWDATA = '0; HREADY = 1'b1; IO_IN = '0;
    m_data = '0; m_oe = '0;
    prev_valid = 1'b0; prev_wr = 1'b0; prev_addr = '0; prev_size = '0; prev_wdata = '0;
    last_rd = '0;

    repeat (2) @(posedge HCLK);
    #1;
    check("rst_io_write", 32'(IO_WRITE), 32'h0);
    check("rst_io_oe", 32'(IO_OE), 32'h0);
    check("rst_hrdata", HRDATA, 32'h0);
    check("rst_hreadyout", 32'(HREADYOUT), 32'h1);
    check("rst_hresp", 32'(HRESP), 32'h0);
    HRESET = 1'b0;

    // Word write then read of DATA.
    bus_cycle(1'b1, 1'b1, 32'h00, HSIZE_WORD, 32'h0000_00A5);
    check("data_before_commit", 32'(IO_WRITE), 32'h0);
    bus_cycle(1'b1, 1'b0, 32'h00, HSIZE_WORD, 32'h0);
    check("data_a5_two_edges", 32'(IO_WRITE), 32'hA5);
    idle();
    check("rd_data_a5", last_rd, 32'h0000_00A5);

    // Back-to-back SET / CLR / TGL.
    bus_cycle(1'b1, 1'b1, 32'h08, HSIZE_WORD, 32'h0A);
    bus_cycle(1'b1, 1'b1, 32'h0C, HSIZE_WORD, 32'h81);
    check("set_0a", 32'(IO_WRITE), 32'hAF);
    bus_cycle(1'b1, 1'b1, 32'h10, HSIZE_WORD, 32'hFF);
    check("clr_81", 32'(IO_WRITE), 32'h2E);
    idle();
    check("tgl_ff", 32'(IO_WRITE), 32'hD1);

    // Byte writes to OE on lane 1 (no effect) and lane 0.
    bus_cycle(1'b1, 1'b1, 32'h05, HSIZE_BYTE, 32'h0000_3C00);
    bus_cycle(1'b1, 1'b1, 32'h04, HSIZE_BYTE, 32'h0000_003C);
    check("oe_lane1_ignored", 32'(IO_OE), 32'h0);
    idle();
    check("oe_lane0_3c", 32'(IO_OE), 32'h3C);
    bus_cycle(1'b1, 1'b0, 32'h04, HSIZE_WORD, 32'h0);
    idle();
    check("rd_oe_3c", last_rd, 32'h3C);

    // Pin readback, unmapped read, write to the read-only IN register.
    IO_IN = 8'h5A;
    repeat (3) idle();
    bus_cycle(1'b1, 1'b0, 32'h14, HSIZE_WORD, 32'h0);
    idle();
    check("rd_in_5a", last_rd, 32'h5A);
    bus_cycle(1'b1, 1'b0, 32'h1C, HSIZE_WORD, 32'h0);
    idle();
    check("rd_1c_zero", last_rd, 32'h0);
    bus_cycle(1'b1, 1'b1, 32'h14, HSIZE_WORD, 32'hFFFF_FFFF);
    idle();
    check("in_write_data", 32'(IO_WRITE), 32'hD1);
    check("in_write_oe", 32'(IO_OE), 32'h3C);

    // Randomized pipelined traffic.
    for (int i = 0; i < 400; i++) begin
      logic [31:0] a;
      if ($urandom_range(0, 15) == 0) IO_IN = W'($urandom);
      a = {27'($urandom), 3'($urandom_range(0, 7)), 2'($urandom_range(0, 3))};
      bus_cycle(($urandom_range(0, 4) != 0), 1'($urandom_range(0, 1)), a,
                3'($urandom_range(0, 7)), $urandom,
                ($urandom_range(0, 7) != 0), ($urandom_range(0, 7) != 0));
    end
    idle();

    // Asynchronous reset during the data phase of a write.
    bus_cycle(1'b1, 1'b1, 32'h00, HSIZE_WORD, 32'h55);
    idle();
    check("pre_reset_55", 32'(IO_WRITE), 32'h55);
    bus_cycle(1'b1, 1'b1, 32'h00, HSIZE_WORD, 32'hFF);
    HSEL = 1'b0; HTRANS = HTRANS_IDLE; HWDATA = 32'hFF;
    #2;
    HRESET = 1'b1;
    #1;
    check("async_rst_io_write", 32'(IO_WRITE), 32'h0);
    check("async_rst_io_oe", 32'(IO_OE), 32'h0);
    check("async_rst_hrdata", HRDATA, 32'h0);
    @(posedge HCLK);
    #1;
    check("rst_write_dropped", 32'(IO_WRITE), 32'h0);
    HRESET = 1'b0;
    m_data = '0; m_oe = '0;
    pin_hist.delete();
    prev_valid = 1'b0; prev_wdata = 32'hFF;
    idle();
    idle();
    check("post_rst_idle", 32'(IO_WRITE), 32'h0);
    check("hreadyout_end", 32'(HREADYOUT), 32'h1);
    check("hresp_end", 32'(HRESP), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/ahblite_gpio_write.md
Name: ahblite_gpio_write

Overview:
AHB-Lite slave that drives the GPIO output pins. It is the output-side counterpart of the GPIO read slave on the same bus matrix. It holds an output data register and an output-enable register, with atomic SET/CLR/TGL aliases and a synchronised pin readback. Zero-wait-state, OKAY-only responder.

Parameters:
GPIO_WIDTH, 8, number of GPIO bits, 1..32, mapped from bit 0 of HWDATA/HRDATA.
DATA_RESET, 0, reset value of the DATA register (low GPIO_WIDTH bits used).
OE_RESET, 0, reset value of the OE register (0 = pin is an input / high-Z).

Ports:
HCLK  in  1  bus clock; all state on rising edge.
HRESET  in  1  asynchronous, active-high reset.
HSEL  in  1  slave select from decoder.
HADDR  in  32  address; only [4:0] decoded.
HTRANS  in  2  transfer type; NONSEQ/SEQ (HTRANS[1]=1) are valid.
HSIZE  in  3  transfer size: byte, half or word.
HPROT  in  4  ignored.
HWRITE  in  1  1 = write.
HWDATA  in  32  write data, valid in data phase.
HREADY  in  1  bus ready; qualifies the address phase.
HREADYOUT  out  1  constant 1.
HRDATA  out  32  read data; upper bits zero.
HRESP  out  1  constant 0 (OKAY).
IO_WRITE  out  GPIO_WIDTH  pin output values (= DATA register).
IO_OE  out  GPIO_WIDTH  per-pin output enable (= OE register).
IO_IN  in  GPIO_WIDTH  raw pin levels, asynchronous.

Behaviour:
- Register map (word offset HADDR[4:2]):
  - 0x00 DATA: RW.
  - 0x04 OE: RW.
  - 0x08 SET: write sets DATA bits where wdata=1; reads DATA.
  - 0x0C CLR: write clears DATA bits where wdata=1; reads DATA.
  - 0x10 TGL: write inverts DATA bits where wdata=1; reads DATA.
  - 0x14 IN: RO; synchronised IO_IN; writes ignored.
  - 0x18 and 0x1C: read 0; writes ignored.
- Address phase accepted when HSEL & HREADY & HTRANS[1]. On that edge, register wr_pend=HWRITE, rd_pend=~HWRITE, addr_q=HADDR[4:2], and lane mask from HSIZE and HADDR[1:0]:
  - byte: 1 lane.
  - half: 2 lanes, by HADDR[1].
  - word: all 4 lanes.
  - HSIZE > word: treated as word.
- A non-accepted cycle (IDLE/BUSY, HSEL=0, HREADY=0) clears wr_pend and rd_pend.
- Data phase write: at the next rising edge, the target register updates using HWDATA bits under the lane mask only. Bits in unmasked lanes are unchanged; for SET/CLR/TGL they are treated as 0.
- Write latency: IO_WRITE/IO_OE change at the edge ending the write data phase. That is 2 edges after the address-phase edge.
- Read: HRDATA is combinational from addr_q and current registers during the data phase. It is 0 when rd_pend=0.
- Back-to-back write then read of the same register returns the new value, with no stall.
- Pipelined transfers: the address phase of N+1 and the data phase of N are captured on the same edge. Pending state must not be lost.
- IN path: 2-flop synchroniser on IO_IN. A pin change is visible in HRDATA at offset 0x14 no sooner than 2 edges after it is sampled.
- HRDATA is not gated by OE; IN always reflects the pins.
- HRESET asserted, asynchronously and at any time, including mid-transfer:
  - DATA=DATA_RESET, OE=OE_RESET, synchroniser=0.
  - wr_pend=rd_pend=0; a pending write is dropped.
- Outputs during reset:
  - IO_WRITE=DATA_RESET, IO_OE=OE_RESET.
  - HRDATA=0, HREADYOUT=1, HRESP=0.

Decomposition:
- Shared package gpio_pkg holds:
  - offset constants GPIO_OFF_DATA/OE/SET/CLR/TGL/IN;
  - HTRANS encodings HTRANS_IDLE/BUSY/NONSEQ/SEQ;
  - HSIZE encodings.
- One sub-module, gpio_sync2: a GPIO_WIDTH-wide 2-flop synchroniser with asynchronous active-high reset.
- Lane-mask generation is a function in gpio_pkg, shared with other AHB slaves.

Test Plan:
- Reset → IO_WRITE=0x00, IO_OE=0x00, HRDATA=0, HREADYOUT=1, HRESP=0.
- Word write 0xA5 to 0x00, then read 0x00 → IO_WRITE=0xA5 two edges after the address phase; read returns 0x000000A5.
- DATA=0xA5:
  - SET 0x0A → 0xAF;
  - CLR 0x81 → 0x2E;
  - TGL 0xFF → 0xD1;
  - each issued back-to-back with no IDLE between.
- Byte write 0x3C to 0x05 (lane 1) → OE unchanged (0x00). Byte write 0x3C to 0x04 → IO_OE=0x3C.
- Drive IO_IN=0x5A → read 0x14 returns 0x5A once 2+ edges have elapsed. A read of 0x1C returns 0. A write to 0x14 leaves all registers unchanged.
- Assert HRESET in the data phase of a write 0xFF to DATA → IO_WRITE stays/returns 0x00. After release, an IDLE cycle causes no write.
